seq_stage_controller: RTL and testbench
=======================================

Name: seq_stage_controller

Overview:
Multi-cycle control sequencer for the Y86 SEQ datapath built from the fetch, decode and execute blocks. It steps one instruction through six stages: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK and PCUPD. It owns the architectural PC, the condition-code register and the Stat register, and raises per-stage enables plus register-file and memory strobes. It replaces free-running PC <= valP clocking and removes CC latching from the testbench.

Parameters:
PC_WIDTH, 64, width of PC, valP, valC and valM.
RESET_PC, 0, PC value loaded on reset.
CNT_WIDTH, 32, width of the cycle and retired-instruction counters.

Ports:
clk  in  1  system clock, rising-edge.
reset  in  1  asynchronous, active-high reset.
run  in  1  level; free-run instructions while high.
step  in  1  single-cycle pulse; execute exactly one instruction from IDLE.
icode  in  4  from fetch.
ifun  in  4  from fetch (unused internally except for pass-through checks).
valC  in  PC_WIDTH  from fetch.
valP  in  PC_WIDTH  from fetch.
valM  in  PC_WIDTH  from data memory (return address).
instr_valid  in  1  from fetch.
imem_error  in  1  from fetch.
dmem_error  in  1  from data memory, sampled in MEMORY.
cnd  in  1  condition result from execute.
cc_in  in  3  {ZF,SF,OF} from execute.
pc  out  PC_WIDTH  architectural PC, feeds fetch.
cc  out  3  committed {ZF,SF,OF}, feeds execute CC_in.
stat  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS.
fetch_en, decode_en, exec_en, mem_en, wb_en  out  1 each  one-hot stage strobes.
reg_we  out  1  register-file write strobe.
mem_we  out  1  data-memory write strobe.
mem_re  out  1  data-memory read strobe.
busy  out  1  high in any stage state.
cycle_cnt  out  CNT_WIDTH  clocks spent in stage states.
instr_cnt  out  CNT_WIDTH  retired instructions.

Behaviour:
- Reset (async, immediate):
  - State IDLE; pc=RESET_PC; cc=3'b100; stat=AOK.
  - All enables and strobes 0; counters 0; busy 0.
  - Reset mid-instruction aborts the instruction with no PC or CC commit.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, PCUPD, HALTED. Enables are registered and one-hot, matching the current state; all are 0 in IDLE, PCUPD and HALTED.
- IDLE: if run or step is high, go to FETCH. A step pulse arms a one-instruction flag.
- FETCH:
  - If imem_error: stat=ADR, go to HALTED.
  - Else if !instr_valid: stat=INS, go to HALTED.
  - Else if icode==0: stat=HLT, go to HALTED. PC is not advanced.
  - Priority among these: ADR > INS > HLT.
- DECODE goes to EXEC.
- EXEC: if icode==6, cc<=cc_in at the end of this cycle. No other icode changes cc.
- MEM:
  - mem_we=1 for icode 4, A, 8.
  - mem_re=1 for icode 5, B, 9.
  - If dmem_error is high with mem_we or mem_re: stat=ADR, go to HALTED. No writeback and no PC commit.
- WB:
  - reg_we=1 for icode 3, 5, 6, A, B, 8, 9.
  - For icode 2, reg_we=cnd.
- PCUPD: new PC is selected as follows.
  - icode 8: valC.
  - icode 7 with cnd: valC.
  - icode 9: valM.
  - Otherwise: valP.
  - instr_cnt increments.
  - Next state is FETCH if run is high and the step flag is clear; otherwise IDLE, clearing the step flag.
- Latency: every instruction takes exactly 6 clocks from FETCH entry to PC commit. cycle_cnt increments each clock while busy.
- run deasserted mid-instruction: the current instruction completes, then the block goes to IDLE.
- run and step both high in IDLE: run wins, and the step flag is ignored.
- HALTED: absorbing state. Only reset exits it. stat, pc and cc are held and counters freeze.
- Counters wrap modulo 2^CNT_WIDTH.

Decomposition:
- Shared package y86_pkg:
  - icode constants: HALT=0, NOP=1, RRMOV=2, IRMOV=3, RMMOV=4, MRMOV=5, OPQ=6, JXX=7, CALL=8, RET=9, PUSH=A, POP=B.
  - Stat codes AOK/HLT/ADR/INS.
  - Stage-state enum.
- One sub-module: seq_pc_select, combinational next-PC mux over icode, cnd, valC, valM and valP. It is reusable by the later PIPE design.

Test Plan:
- Reset, then run=1 with nop at 0 followed by halt at 1: fetch_en pulses at cycles 1 and 7; pc=1 after the first PCUPD; stat=2; instr_cnt=1; pc stays 1.
- Program "irmovq $-1,%rdx; addq %rdx,%rbx" with cc_in=3'b010 from execute during OPq: cc goes 100→010 only on the OPq EXEC cycle and stays 100 through irmovq.
- jmp with valC=0x1011 and cnd=1: pc=0x1011. jne with cnd=0 and valP=0x18: pc=0x18.
- Invalid opcode byte 0xF0 at PC=0x26: stat=4, HALTED, pc=0x26, no reg_we or mem_we ever asserted, instr_cnt unchanged.
- step pulse while run=0: exactly one instruction (6 busy cycles), then IDLE, instr_cnt+1. A second step executes the next instruction.
- reset asserted during MEM of pushq: immediate IDLE; mem_we drops asynchronously; pc=0; cc=100; counters 0.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86 definitions: instruction codes, status codes and the
// stage-state encoding used by the SEQ controller and later PIPE work.
package y86_pkg;

    localparam logic [3:0] I_HALT  = 4'h0;
    localparam logic [3:0] I_NOP   = 4'h1;
    localparam logic [3:0] I_RRMOV = 4'h2;
    localparam logic [3:0] I_IRMOV = 4'h3;
    localparam logic [3:0] I_RMMOV = 4'h4;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OPQ   = 4'h6;
    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_PUSH  = 4'hA;
    localparam logic [3:0] I_POP   = 4'hB;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    // {ZF,SF,OF} after reset: zero flag set
    localparam logic [2:0] CC_RESET = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_PCUPD,
        S_HALTED
    } stage_e;

endpackage

// File: rtl/seq_pc_select.sv
// Next-PC selection for Y86: call/taken jump -> valC, ret -> valM,
// everything else falls through to valP.
module seq_pc_select
    import y86_pkg::*;
#(
    parameter int PC_WIDTH = 64
) (
    input  logic [3:0]          icode,
    input  logic                cnd,
    input  logic [PC_WIDTH-1:0] valC,
    input  logic [PC_WIDTH-1:0] valM,
    input  logic [PC_WIDTH-1:0] valP,
    output logic [PC_WIDTH-1:0] new_pc
);

    always_comb begin
        new_pc = valP;
        case (icode)
            I_CALL:  new_pc = valC;
            I_JXX:   new_pc = cnd ? valC : valP;
            I_RET:   new_pc = valM;
            default: new_pc = valP;
        endcase
    end

endmodule

// File: rtl/seq_stage_controller.sv
// Six-stage multi-cycle sequencer for the Y86 SEQ datapath; owns PC,
// CC and Stat and issues stage enables and register/memory strobes.
module seq_stage_controller
    import y86_pkg::*;
#(
    parameter int                 PC_WIDTH  = 64,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter int                 CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic                 step,
    input  logic [3:0]           icode,
    input  logic [3:0]           ifun,
    input  logic [PC_WIDTH-1:0]  valC,
    input  logic [PC_WIDTH-1:0]  valP,
    input  logic [PC_WIDTH-1:0]  valM,
    input  logic                 instr_valid,
    input  logic                 imem_error,
    input  logic                 dmem_error,
    input  logic                 cnd,
    input  logic [2:0]           cc_in,
    output logic [PC_WIDTH-1:0]  pc,
    output logic [2:0]           cc,
    output logic [2:0]           stat,
    output logic                 fetch_en,
    output logic                 decode_en,
    output logic                 exec_en,
    output logic                 mem_en,
    output logic                 wb_en,
    output logic                 reg_we,
    output logic                 mem_we,
    output logic                 mem_re,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] cycle_cnt,
    output logic [CNT_WIDTH-1:0] instr_cnt
);

    stage_e               state_q, state_d;
    logic                 step_flag_q, step_flag_d;
    logic [PC_WIDTH-1:0]  pc_q, pc_d, new_pc;
    logic [2:0]           cc_q, cc_d;
    logic [2:0]           stat_q, stat_d;
    logic [CNT_WIDTH-1:0] cycle_q, cycle_d;
    logic [CNT_WIDTH-1:0] instr_q, instr_d;
    logic [4:0]           en_q, en_d;
    logic                 unused_ifun;

    assign unused_ifun = ^ifun;

    seq_pc_select #(.PC_WIDTH(PC_WIDTH)) u_pc_select (
        .icode  (icode),
        .cnd    (cnd),
        .valC   (valC),
        .valM   (valM),
        .valP   (valP),
        .new_pc (new_pc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            step_flag_q <= 1'b0;
            pc_q        <= RESET_PC;
            cc_q        <= CC_RESET;
            stat_q      <= STAT_AOK;
            cycle_q     <= '0;
            instr_q     <= '0;
            en_q        <= '0;
        end else begin
            state_q     <= state_d;
            step_flag_q <= step_flag_d;
            pc_q        <= pc_d;
            cc_q        <= cc_d;
            stat_q      <= stat_d;
            cycle_q     <= cycle_d;
            instr_q     <= instr_d;
            en_q        <= en_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        step_flag_d = step_flag_q;
        pc_d        = pc_q;
        cc_d        = cc_q;
        stat_d      = stat_q;
        instr_d     = instr_q;
        cycle_d     = busy ? cycle_q + CNT_WIDTH'(1) : cycle_q;
        case (state_q)
            S_IDLE: begin
                if (run || step) begin
                    state_d     = S_FETCH;
                    step_flag_d = !run;
                end
            end
            S_FETCH: begin
                state_d = S_HALTED;
                if (imem_error)          stat_d = STAT_ADR;
                else if (!instr_valid)   stat_d = STAT_INS;
                else if (icode == I_HALT) stat_d = STAT_HLT;
                else                     state_d = S_DECODE;
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if (icode == I_OPQ) cc_d = cc_in;
                state_d = S_MEM;
            end
            S_MEM: begin
                // a faulting access abandons writeback and the PC commit
                if (dmem_error && (mem_we || mem_re)) begin
                    stat_d  = STAT_ADR;
                    state_d = S_HALTED;
                end else begin
                    state_d = S_WB;
                end
            end
            S_WB: state_d = S_PCUPD;
            S_PCUPD: begin
                pc_d    = new_pc;
                instr_d = instr_q + CNT_WIDTH'(1);
                if (run && !step_flag_q) begin
                    state_d = S_FETCH;
                end else begin
                    state_d     = S_IDLE;
                    step_flag_d = 1'b0;
                end
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q != S_IDLE) && (state_q != S_HALTED);
    assign en_d = {state_d == S_FETCH, state_d == S_DECODE,
                   state_d == S_EXEC, state_d == S_MEM, state_d == S_WB};

    always_comb begin
        mem_we = 1'b0;
        mem_re = 1'b0;
        reg_we = 1'b0;
        if (state_q == S_MEM) begin
            mem_we = icode inside {I_RMMOV, I_PUSH, I_CALL};
            mem_re = icode inside {I_MRMOV, I_POP, I_RET};
        end
        if (state_q == S_WB) begin
            reg_we = (icode inside {I_IRMOV, I_MRMOV, I_OPQ, I_PUSH,
                                    I_POP, I_CALL, I_RET})
                   || (icode == I_RRMOV && cnd);
        end
    end

    assign pc        = pc_q;
    assign cc        = cc_q;
    assign stat      = stat_q;
    assign cycle_cnt = cycle_q;
    assign instr_cnt = instr_q;
    assign {fetch_en, decode_en, exec_en, mem_en, wb_en} = en_q;

endmodule

// File: tb/tb_seq_stage_controller.sv
// Scoreboard bench for seq_stage_controller: a tiny program table feeds
// the fetch inputs and expected commit/halt states are queued per test.
module tb_seq_stage_controller;
    import y86_pkg::*;

    logic        clk = 1'b0;
    logic        reset, run, step;
    logic [3:0]  icode, ifun;
    logic [63:0] valC, valP, valM;
    logic        instr_valid, imem_error, dmem_error, cnd;
    logic [2:0]  cc_in;
    logic [63:0] pc;
    logic [2:0]  cc, stat;
    logic        fetch_en, decode_en, exec_en, mem_en, wb_en;
    logic        reg_we, mem_we, mem_re, busy;
    logic [31:0] cycle_cnt, instr_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_stage_controller dut (
        .clk(clk), .reset(reset), .run(run), .step(step),
        .icode(icode), .ifun(ifun), .valC(valC), .valP(valP), .valM(valM),
        .instr_valid(instr_valid), .imem_error(imem_error),
        .dmem_error(dmem_error), .cnd(cnd), .cc_in(cc_in),
        .pc(pc), .cc(cc), .stat(stat),
        .fetch_en(fetch_en), .decode_en(decode_en), .exec_en(exec_en),
        .mem_en(mem_en), .wb_en(wb_en),
        .reg_we(reg_we), .mem_we(mem_we), .mem_re(mem_re), .busy(busy),
        .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
    );

    typedef struct {
        logic [63:0] a;
        logic [3:0]  ic;
        logic [63:0] c, p, m;
        logic        cn, v, ie, de;
    } ent_t;

    typedef struct {
        logic [63:0] pc;
        logic [2:0]  cc, st;
        logic [31:0] n;
    } exp_t;

    ent_t prog [8];
    int   nprog = 0;
    exp_t sbq [$];

    // fetch/execute/memory stand-in: look up the instruction at pc
    always @(negedge clk) begin
        icode = I_HALT; ifun = 4'h0; valC = '0; valP = pc + 64'd1;
        valM = '0; cnd = 1'b0; instr_valid = 1'b1;
        imem_error = 1'b0; dmem_error = 1'b0;
        for (int i = 0; i < nprog; i++) begin
            if (prog[i].a == pc) begin
                icode = prog[i].ic; valC = prog[i].c; valP = prog[i].p;
                valM = prog[i].m; cnd = prog[i].cn; instr_valid = prog[i].v;
                imem_error = prog[i].ie; dmem_error = prog[i].de;
            end
        end
    end

    task automatic add(input logic [63:0] a, input logic [3:0] ic,
                       input logic [63:0] c, input logic [63:0] p,
                       input logic [63:0] m, input logic cn,
                       input logic v, input logic ie, input logic de);
        prog[nprog] = '{a, ic, c, p, m, cn, v, ie, de};
        nprog++;
    endtask

    task automatic push_exp(input logic [63:0] p, input logic [2:0] c,
                            input logic [2:0] s, input logic [31:0] n);
        exp_t e;
        e.pc = p; e.cc = c; e.st = s; e.n = n;
        sbq.push_back(e);
    endtask

    task automatic do_reset();
        reset = 1'b1; run = 1'b0; step = 1'b0; cc_in = 3'b010;
        nprog = 0; sbq.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; run = 1'b0; step = 1'b0; cc_in = 3'b010;
        #2;
        total++;
        if (pc !== 64'd0 || cc !== 3'b100 || stat !== STAT_AOK) begin
            bad++;
            $display("FAIL reset_arch pc=%h cc=%b stat=%0d want 0/100/1", pc, cc, stat);
        end
        total++;
        if ({fetch_en, decode_en, exec_en, mem_en, wb_en,
             reg_we, mem_we, mem_re, busy} !== 9'd0) begin
            bad++;
            $display("FAIL reset_strobes got some strobe high want all 0");
        end
        total++;
        if (cycle_cnt !== 32'd0 || instr_cnt !== 32'd0) begin
            bad++;
            $display("FAIL reset_cnt cyc=%0d ins=%0d want 0/0", cycle_cnt, instr_cnt);
        end
        do_reset();
    endtask

    task automatic test_nop_halt();
        exp_t e; logic [31:0] last; logic done; logic [31:0] fmask;
        do_reset();
        add(0, I_NOP, 0, 1, 0, 0, 1, 0, 0);
        add(1, I_HALT, 0, 2, 0, 0, 1, 0, 0);
        push_exp(1, 3'b100, STAT_AOK, 1);
        push_exp(1, 3'b100, STAT_HLT, 1);
        @(negedge clk); run = 1'b1;
        last = 0; done = 0; fmask = 0;
        for (int k = 1; k <= 20 && !done; k++) begin
            @(posedge clk); #1;
            fmask[k] = fetch_en;
            if (instr_cnt !== last || stat !== STAT_AOK) begin
                total++;
                if (sbq.size() == 0) begin
                    bad++; done = 1;
                    $display("FAIL nop_halt extra event pc=%h stat=%0d", pc, stat);
                end else begin
                    e = sbq.pop_front();
                    if (pc !== e.pc || cc !== e.cc || stat !== e.st || instr_cnt !== e.n) begin
                        bad++;
                        $display("FAIL nop_halt sb got pc=%h cc=%b st=%0d n=%0d want pc=%h cc=%b st=%0d n=%0d",
                                 pc, cc, stat, instr_cnt, e.pc, e.cc, e.st, e.n);
                    end
                    last = instr_cnt;
                    if (stat !== STAT_AOK) done = 1;
                end
            end
        end
        total++;
        if (!done || sbq.size() != 0) begin
            bad++; $display("FAIL nop_halt timeout left=%0d want 0", sbq.size());
        end
        total++;
        if (fmask !== 32'h82) begin
            bad++; $display("FAIL nop_halt fetch_en cycles got %h want 82", fmask);
        end
        repeat (5) @(posedge clk); #1;
        total++;
        if (pc !== 64'd1 || busy !== 1'b0 || cycle_cnt !== 32'd7 || stat !== STAT_HLT) begin
            bad++;
            $display("FAIL halted_hold pc=%h busy=%b cyc=%0d st=%0d want 1/0/7/2", pc, busy, cycle_cnt, stat);
        end
    endtask

    task automatic test_cc();
        exp_t e; logic [31:0] last; logic done; int rw;
        do_reset();
        add(0, I_IRMOV, 64'hFFFF_FFFF_FFFF_FFFF, 10, 0, 0, 1, 0, 0);
        add(10, I_OPQ, 0, 12, 0, 0, 1, 0, 0);
        push_exp(10, 3'b100, STAT_AOK, 1);
        push_exp(12, 3'b010, STAT_AOK, 2);
        push_exp(12, 3'b010, STAT_HLT, 2);
        @(negedge clk); run = 1'b1;
        last = 0; done = 0; rw = 0;
        for (int k = 1; k <= 30 && !done; k++) begin
            @(posedge clk); #1;
            if (reg_we) rw++;
            total++;
            if (cc !== ((k >= 10) ? 3'b010 : 3'b100)) begin
                bad++; $display("FAIL cc_trace cycle %0d got %b", k, cc);
            end
            if (instr_cnt !== last || stat !== STAT_AOK) begin
                total++;
                if (sbq.size() == 0) begin
                    bad++; done = 1;
                    $display("FAIL cc extra event pc=%h stat=%0d", pc, stat);
                end else begin
                    e = sbq.pop_front();
                    if (pc !== e.pc || cc !== e.cc || stat !== e.st || instr_cnt !== e.n) begin
                        bad++;
                        $display("FAIL cc sb got pc=%h cc=%b st=%0d n=%0d want pc=%h cc=%b st=%0d n=%0d",
                                 pc, cc, stat, instr_cnt, e.pc, e.cc, e.st, e.n);
                    end
                    last = instr_cnt;
                    if (stat !== STAT_AOK) done = 1;
                end
            end
        end
        total++;
        if (!done || sbq.size() != 0 || rw != 2) begin
            bad++; $display("FAIL cc end left=%0d reg_we=%0d want 0/2", sbq.size(), rw);
        end
    endtask

    task automatic test_branches();
        exp_t e; logic [31:0] last; logic done; int rw, mw, mr;
        do_reset();
        add(0, I_JXX, 64'h1011, 9, 0, 1, 1, 0, 0);
        add(64'h1011, I_JXX, 64'h500, 64'h18, 0, 0, 1, 0, 0);
        add(64'h18, I_CALL, 64'h40, 64'h21, 0, 0, 1, 0, 0);
        add(64'h40, I_RET, 0, 64'h41, 64'h21, 0, 1, 0, 0);
        push_exp(64'h1011, 3'b100, STAT_AOK, 1);
        push_exp(64'h18, 3'b100, STAT_AOK, 2);
        push_exp(64'h40, 3'b100, STAT_AOK, 3);
        push_exp(64'h21, 3'b100, STAT_AOK, 4);
        push_exp(64'h21, 3'b100, STAT_HLT, 4);
        @(negedge clk); run = 1'b1;
        last = 0; done = 0; rw = 0; mw = 0; mr = 0;
        for (int k = 1; k <= 40 && !done; k++) begin
            @(posedge clk); #1;
            if (reg_we) rw++;
            if (mem_we) mw++;
            if (mem_re) mr++;
            if (instr_cnt !== last || stat !== STAT_AOK) begin
                total++;
                if (sbq.size() == 0) begin
                    bad++; done = 1;
                    $display("FAIL branch extra event pc=%h stat=%0d", pc, stat);
                end else begin
                    e = sbq.pop_front();
                    if (pc !== e.pc || cc !== e.cc || stat !== e.st || instr_cnt !== e.n) begin
                        bad++;
                        $display("FAIL branch sb got pc=%h st=%0d n=%0d want pc=%h st=%0d n=%0d",
                                 pc, stat, instr_cnt, e.pc, e.st, e.n);
                    end
                    last = instr_cnt;
                    if (stat !== STAT_AOK) done = 1;
                end
            end
        end
        total++;
        if (!done || sbq.size() != 0 || rw != 2 || mw != 1 || mr != 1) begin
            bad++;
            $display("FAIL branch end left=%0d rw=%0d mw=%0d mr=%0d want 0/2/1/1",
                     sbq.size(), rw, mw, mr);
        end
    endtask

    task automatic test_faults();
        exp_t e; logic [31:0] last; logic done; int rw, mw;
        for (int t = 0; t < 3; t++) begin
            do_reset();
            case (t)
                0: begin
                    add(0, I_JXX, 64'h26, 9, 0, 1, 1, 0, 0);
                    add(64'h26, 4'hF, 0, 64'h27, 0, 0, 0, 0, 0);
                    push_exp(64'h26, 3'b100, STAT_AOK, 1);
                    push_exp(64'h26, 3'b100, STAT_INS, 1);
                end
                1: begin
                    add(0, 4'hF, 0, 1, 0, 0, 0, 1, 0);
                    push_exp(0, 3'b100, STAT_ADR, 0);
                end
                default: begin
                    add(0, I_PUSH, 0, 2, 0, 0, 1, 0, 1);
                    push_exp(0, 3'b100, STAT_ADR, 0);
                end
            endcase
            @(negedge clk); run = 1'b1;
            last = 0; done = 0; rw = 0; mw = 0;
            for (int k = 1; k <= 20 && !done; k++) begin
                @(posedge clk); #1;
                if (reg_we) rw++;
                if (mem_we) mw++;
                if (instr_cnt !== last || stat !== STAT_AOK) begin
                    total++;
                    if (sbq.size() == 0) begin
                        bad++; done = 1;
                        $display("FAIL fault%0d extra event pc=%h stat=%0d", t, pc, stat);
                    end else begin
                        e = sbq.pop_front();
                        if (pc !== e.pc || cc !== e.cc || stat !== e.st || instr_cnt !== e.n) begin
                            bad++;
                            $display("FAIL fault%0d sb got pc=%h st=%0d n=%0d want pc=%h st=%0d n=%0d",
                                     t, pc, stat, instr_cnt, e.pc, e.st, e.n);
                        end
                        last = instr_cnt;
                        if (stat !== STAT_AOK) done = 1;
                    end
                end
            end
            total++;
            if (!done || sbq.size() != 0 || rw != 0 || mw != ((t == 2) ? 1 : 0)) begin
                bad++;
                $display("FAIL fault%0d end left=%0d rw=%0d mw=%0d", t, sbq.size(), rw, mw);
            end
        end
    endtask

    task automatic test_step_run_drop();
        exp_t e; logic [31:0] last; int bc;
        do_reset();
        add(0, I_NOP, 0, 1, 0, 0, 1, 0, 0);
        add(1, I_NOP, 0, 2, 0, 0, 1, 0, 0);
        add(2, I_NOP, 0, 3, 0, 0, 1, 0, 0);
        last = 0;
        for (int p = 0; p < 3; p++) begin
            push_exp(64'(p + 1), 3'b100, STAT_AOK, 32'(p + 1));
            @(negedge clk);
            if (p < 2) step = 1'b1;
            else run = 1'b1;
            bc = 0;
            for (int k = 1; k <= 10; k++) begin
                @(posedge clk); #1;
                step = 1'b0; run = 1'b0;
                if (busy) bc++;
                if (instr_cnt !== last) begin
                    total++;
                    if (sbq.size() == 0) begin
                        bad++; $display("FAIL step%0d extra retire n=%0d", p, instr_cnt);
                    end else begin
                        e = sbq.pop_front();
                        if (pc !== e.pc || stat !== e.st || instr_cnt !== e.n) begin
                            bad++;
                            $display("FAIL step%0d sb got pc=%h n=%0d want pc=%h n=%0d",
                                     p, pc, instr_cnt, e.pc, e.n);
                        end
                    end
                    last = instr_cnt;
                end
            end
            total++;
            if (bc != 6 || busy !== 1'b0 || sbq.size() != 0) begin
                bad++;
                $display("FAIL step%0d busy_cycles=%0d busy=%b left=%0d want 6/0/0",
                         p, bc, busy, sbq.size());
            end
        end
        total++;
        if (cycle_cnt !== 32'd18) begin
            bad++; $display("FAIL step cycle_cnt got %0d want 18", cycle_cnt);
        end
    endtask

    task automatic test_reset_mid_mem();
        exp_t e; logic [31:0] last;
        do_reset();
        add(0, I_OPQ, 0, 64'h30, 0, 0, 1, 0, 0);
        add(64'h30, I_PUSH, 0, 64'h32, 0, 0, 1, 0, 0);
        push_exp(64'h30, 3'b010, STAT_AOK, 1);
        @(negedge clk); run = 1'b1;
        last = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (instr_cnt !== last) begin
                total++;
                e = sbq.pop_front();
                if (pc !== e.pc || cc !== e.cc || instr_cnt !== e.n) begin
                    bad++;
                    $display("FAIL rstmem sb got pc=%h cc=%b n=%0d want pc=%h cc=%b n=%0d",
                             pc, cc, instr_cnt, e.pc, e.cc, e.n);
                end
                last = instr_cnt;
            end
        end
        total++;
        if (mem_we !== 1'b1 || mem_en !== 1'b1) begin
            bad++; $display("FAIL rstmem in_mem mem_we=%b mem_en=%b want 1/1", mem_we, mem_en);
        end
        #1 reset = 1'b1;
        #1;
        total++;
        if (mem_we !== 1'b0 || mem_en !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL rstmem strobes mem_we=%b mem_en=%b busy=%b want 0", mem_we, mem_en, busy);
        end
        total++;
        if (pc !== 64'd0 || cc !== 3'b100 || stat !== STAT_AOK ||
            cycle_cnt !== 32'd0 || instr_cnt !== 32'd0) begin
            bad++;
            $display("FAIL rstmem arch pc=%h cc=%b st=%0d cyc=%0d n=%0d want 0/100/1/0/0",
                     pc, cc, stat, cycle_cnt, instr_cnt);
        end
        @(negedge clk);
        run = 1'b0; reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_nop_halt();
        test_cc();
        test_branches();
        test_faults();
        test_step_run_drop();
        test_reset_mid_mem();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
